// File: rtl/instr_feeder.sv
// Program-buffer sequencer for the cpu's instruction side. It issues each buffered word with the
// load/s/w handshake and captures the result and flags after each instruction.
module instr_feeder #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [15:0]   wr_data,
  input  logic          start,
  input  logic          cpu_w,
  input  logic [15:0]   cpu_out,
  input  logic          cpu_N,
  input  logic          cpu_V,
  input  logic          cpu_Z,
  output logic [15:0]   cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          ovf,
  output logic [AW:0]   len,
  output logic [AW:0]   issued,
  output logic [15:0]   last_out,
  output logic [2:0]    last_flags
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StGo, StExec, StCap, StDone, StErr
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] mem [DEPTH];
  logic [15:0] mem_rd;
  logic        mem_we;
  logic [AW:0] len_q, len_d, pc_q, pc_d, issued_q, issued_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        tmo_hit;
  logic [15:0] ir_q, ir_d, last_out_q, last_out_d;
  logic [2:0]  flags_q, flags_d;
  logic        ovf_q, ovf_d;

  assign mem_rd  = mem[pc_q[AW-1:0]];
  // The entry cycle counts, so the last permitted cycle is TIMEOUT-1 cycles after entry.
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pc_d       = pc_q;
    issued_d   = issued_q;
    ir_d       = ir_q;
    last_out_d = last_out_q;
    flags_d    = flags_q;
    ovf_d      = ovf_q;
    mem_we     = 1'b0;

    if ((state_q == StIdle) && wr_en) begin
      if (len_q == (AW+1)'(DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        mem_we = 1'b1;
        len_d  = len_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len_q == '0) begin
            state_d = StDone;
          end else begin
            pc_d     = '0;
            issued_d = '0;
            state_d  = StLoad;
          end
        end
      end
      StLoad: begin
        ir_d    = mem_rd;
        state_d = StGo;
      end
      StGo: begin
        if (!cpu_w)       state_d = StExec;
        else if (tmo_hit) state_d = StErr;
      end
      StExec: begin
        if (cpu_w)        state_d = StCap;
        else if (tmo_hit) state_d = StErr;
      end
      StCap: begin
        last_out_d = cpu_out;
        flags_d    = {cpu_N, cpu_V, cpu_Z};
        issued_d   = issued_q + 1'b1;
        pc_d       = pc_q + 1'b1;
        state_d    = ((pc_q + 1'b1) == len_q) ? StDone : StLoad;
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase

    if ((state_d != state_q) || !((state_q == StGo) || (state_q == StExec))) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      pc_q       <= '0;
      issued_q   <= '0;
      tmo_q      <= '0;
      ir_q       <= '0;
      last_out_q <= '0;
      flags_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pc_q       <= pc_d;
      issued_q   <= issued_d;
      tmo_q      <= tmo_d;
      ir_q       <= ir_d;
      last_out_q <= last_out_d;
      flags_q    <= flags_d;
      ovf_q      <= ovf_d;
    end
  end

  // Buffer storage has no reset; only entries below len are ever read.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[len_q[AW-1:0]] <= wr_data;
    end
  end

  assign cpu_in     = (state_q == StLoad) ? mem_rd : ir_q;
  assign cpu_load   = (state_q == StLoad);
  assign cpu_s      = (state_q == StGo);
  assign busy       = (state_q != StIdle) && (state_q != StErr);
  assign done       = (state_q == StDone);
  assign error      = (state_q == StErr);
  assign ovf        = ovf_q;
  assign len        = len_q;
  assign issued     = issued_q;
  assign last_out   = last_out_q;
  assign last_flags = flags_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: a small behavioural cpu answers the handshake, and a transaction-level
// model predicts buffer state, issued words and captured results.
module tb_instr_feeder;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0;
  logic [15:0] wr_data = '0;
  logic        cpu_w = 1'b1, cpu_N = 1'b0, cpu_V = 1'b0, cpu_Z = 1'b0;
  logic [15:0] cpu_out = '0;
  logic [15:0] cpu_in, last_out;
  logic        cpu_load, cpu_s, busy, done, error, ovf;
  logic [AW:0] len, issued;
  logic [2:0]  last_flags;

  instr_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .cpu_w(cpu_w), .cpu_out(cpu_out), .cpu_N(cpu_N), .cpu_V(cpu_V), .cpu_Z(cpu_Z),
    .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s), .busy(busy), .done(done),
    .error(error), .ovf(ovf), .len(len), .issued(issued), .last_out(last_out),
    .last_flags(last_flags)
  );

  always #5 clk = ~clk;

  // Tiny ISA subset: MOV Rn,#imm8 / MOV Rd,Rm / CMP Rn,Rm.
  typedef struct packed {
    logic [7:0][15:0] r;
    logic [15:0]      out;
    logic [2:0]       fl;
  } cpu_t;

  function automatic cpu_t isa(cpu_t s, logic [15:0] ir);
    cpu_t        n = s;
    logic [15:0] a, b, d;
    a = s.r[ir[10:8]];
    b = s.r[ir[2:0]];
    d = a - b;
    case (ir[15:11])
      5'b11010: n.r[ir[10:8]] = {{8{ir[7]}}, ir[7:0]};
      5'b11000: begin n.r[ir[7:5]] = b; n.out = b; end
      5'b10101: n.fl = {d[15], (a[15] != b[15]) && (d[15] != a[15]), d == 16'h0};
      default: ;
    endcase
    return n;
  endfunction

  // Behavioural cpu: drops w one cycle into s, raises it exec_lat cycles later with results.
  cpu_t        emu;
  logic [15:0] emu_ir = '0;
  int          exec_lat = 2;
  bit          stuck = 1'b0;
  initial begin
    emu = '0;
    forever begin
      @(negedge clk);
      if (cpu_load) emu_ir = cpu_in;
      if (cpu_s && cpu_w && !stuck) begin
        cpu_w = 1'b0;
        repeat (exec_lat) @(negedge clk);
        emu     = isa(emu, emu_ir);
        cpu_out = emu.out;
        {cpu_N, cpu_V, cpu_Z} = emu.fl;
        cpu_w   = 1'b1;
      end
    end
  end

  cpu_t        mdl;
  logic [15:0] mmem [DEPTH];
  logic [15:0] exp_q [$];
  int          m_len = 0, m_issued = 0, m_done_exp = 0;
  bit          m_ovf = 1'b0, m_err = 1'b0;
  logic [15:0] m_last = '0;
  logic [2:0]  m_flags = '0;
  int          n_chk = 0, n_pass = 0, n_done = 0, s_cycles = 0;
  bit          chk_en = 1'b0;
  logic        prev_done = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("len", len, m_len);
      chk("ovf", ovf, m_ovf);
      chk("error", error, m_err);
      chk("load_and_s", cpu_load & cpu_s, 0);
      chk("done_width", done & prev_done, 0);
      if (cpu_load) begin
        if (exp_q.size() == 0) chk("unexpected_load", 1, 0);
        else chk("cpu_in", cpu_in, exp_q.pop_front());
      end
      if (cpu_s) s_cycles <= s_cycles + 1;
      if (done) begin
        n_done <= n_done + 1;
        chk("done_issued", issued, m_issued);
        chk("done_last_out", last_out, m_last);
        chk("done_last_flags", last_flags, m_flags);
        chk("busy_in_done", busy, 1);
      end
      if (m_err) begin
        chk("err_busy", busy, 0);
        chk("err_s", cpu_s, 0);
        chk("err_load", cpu_load, 0);
      end else if (!busy) begin
        chk("idle_issued", issued, m_issued);
        chk("idle_last_out", last_out, m_last);
        chk("idle_last_flags", last_flags, m_flags);
        chk("idle_s", cpu_s, 0);
      end
      prev_done <= done;
    end
  end

  task automatic clr_model();
    m_len = 0; m_ovf = 1'b0; m_err = 1'b0; m_issued = 0; m_last = '0; m_flags = '0;
    exp_q.delete();
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    clr_model();
    #1 reset = 1'b0;
  endtask

  task automatic wr(logic [15:0] d, bit accept);
    wr_en = 1'b1; wr_data = d;
    @(posedge clk);
    if (accept) begin
      if (m_len < DEPTH) begin mmem[m_len] = d; m_len++; end
      else m_ovf = 1'b1;
    end
    #1 wr_en = 1'b0;
  endtask

  task automatic run(bit expect_done);
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < m_len; i++) begin
      exp_q.push_back(mmem[i]);
      if (expect_done) mdl = isa(mdl, mmem[i]);
    end
    if (expect_done) begin
      if (m_len > 0) begin m_issued = m_len; m_last = mdl.out; m_flags = mdl.fl; end
      m_done_exp++;
    end
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    int d0 = n_done;
    cyc = 0;
    while (n_done == d0 && cyc < 500) begin @(negedge clk); #1; cyc++; end
    if (n_done == d0) chk("done_timeout", 0, 1);
    else begin @(negedge clk); chk("busy_after_done", busy, 0); end
    chk("loads_left", exp_q.size(), 0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, s0, k;
    bit seen_s;
    mdl = '0;

    // Reset held for two edges, then an empty start
    @(posedge clk);
    clr_model();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_cpu_in", cpu_in, 0);
    chk("reset_ctrl", {cpu_load, cpu_s, busy, done, error, ovf}, 0);
    chk("reset_counts", {len, issued}, 0);
    chk("reset_capture", {last_out, last_flags}, 0);
    step();
    reset = 1'b0;
    run(1);
    wait_done(cyc);
    chk("empty_run_cycles", cyc, 1);
    chk("empty_issued", issued, 0);

    // Two-instruction program: 5 cycles each with a 2-cycle cpu, plus DONE
    wr(16'hD004, 1);
    wr(16'hC020, 1);
    run(1);
    wait_done(cyc);
    chk("run2_cycles", cyc, 11);
    chk("run2_issued", issued, 2);
    chk("run2_last_out", last_out, 16'h0004);

    // Append CMP, write during the run is dropped, then re-run
    wr(16'hA801, 1);
    run(1);
    wr(16'hFFFF, 0);
    wait_done(cyc);
    chk("run3_issued", issued, 3);
    chk("run3_flags", last_flags, 3'b001);
    chk("run3_last_out", last_out, 16'h0004);
    run(1);
    wait_done(cyc);
    chk("rerun_cycles", cyc, 16);
    chk("rerun_issued", issued, 3);
    chk("rerun_flags", last_flags, 3'b001);

    // Stuck cpu: GO lasts TIMEOUT cycles, then sticky error
    do_reset();
    stuck = 1'b1;
    wr(16'hD004, 1);
    s0 = s_cycles;
    run(0);
    repeat (TIMEOUT + 1) @(posedge clk);
    m_err = 1'b1;
    @(negedge clk); #1;
    chk("go_cycles", s_cycles - s0, TIMEOUT);
    chk("err_set", {error, busy, cpu_s}, 3'b100);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("err_sticky", {error, busy, cpu_s, cpu_load}, 4'b1000);
    chk("err_no_done", n_done, m_done_exp);
    stuck = 1'b0;

    // Overflow on the 17th write
    do_reset();
    for (int i = 0; i < 17; i++) wr(16'(16'h1000 + i), 1);
    @(negedge clk);
    chk("full_len", len, 16);
    chk("full_ovf", ovf, 1);
    step();

    // Reset while the cpu is executing
    do_reset();
    exec_lat = 4;
    wr(16'hD004, 1);
    wr(16'hC020, 1);
    run(0);
    k = 0; seen_s = 1'b0;
    while (k < 100) begin
      @(negedge clk); #1; k++;
      if (cpu_s) seen_s = 1'b1;
      else if (seen_s && busy) break;
    end
    chk("reach_exec", (k < 100), 1);
    do_reset();
    @(negedge clk);
    chk("rst_exec_ctrl", {busy, cpu_s, cpu_load, done}, 0);
    chk("rst_exec_counts", {len, issued}, 0);
    repeat (6) step();
    chk("done_count", n_done, m_done_exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
